bp_be_fe_queue_rx: RTL and testbench
====================================

BP_BE_FE_QUEUE_RX -- requirements
Module: bp_be_fe_queue_rx

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg: processor configuration from which all widths derive.
REQ-002 SHALL have parameter fifo_els_p, default 4: fe_queue buffer depth, power of two, at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port fe_queue_i, input, fe_queue_width_lp bits: bp_fe_queue_s message from the FE.
REQ-006 SHALL have port fe_queue_v_i, input, 1 bit: FE message valid.
REQ-007 SHALL have port fe_queue_ready_o, output, 1 bit: buffer can accept a message this cycle.
REQ-008 SHALL have port issue_pkt_o, output, fe_queue_width_lp bits: head buffer entry.
REQ-009 SHALL have ports issue_v_o (output, 1 bit) and issue_yumi_i (input, 1 bit): head valid, and head consumed by BE issue.
REQ-010 SHALL have ports redirect_v_i (input, 1), redirect_pkt_i (input, fe_cmd_width_lp) and cmd_ready_o (output, 1): BE non-attaboy command request, and command slot free.
REQ-011 SHALL have ports attaboy_v_i (input, 1) and attaboy_pkt_i (input, fe_cmd_width_lp): BE attaboy request.
REQ-012 SHALL have ports fe_cmd_o (output, fe_cmd_width_lp), fe_cmd_v_o (output, 1) and fe_cmd_yumi_i (input, 1): command to the FE.

Function
REQ-013 SHALL have states e_run, e_cmd_wait and e_fault_wait.
REQ-014 SHALL drive fe_queue_ready_o = (state != e_cmd_wait) & ~full.
- Message with fe_queue_v_i & fe_queue_ready_o SHALL be written at the tail.
- Message with fe_queue_v_i & ~fe_queue_ready_o SHALL be dropped without error.
- Message arriving in e_cmd_wait SHALL be dropped, because it is stale.
REQ-015 SHALL drive issue_v_o = ~empty; issue_pkt_o = head entry, combinational from storage.
- issue_yumi_i SHALL pop the head.
- issue_yumi_i when empty SHALL be ignored.
- Simultaneous push and pop when full SHALL be disallowed, because ready is based on full.
REQ-016 Pointers SHALL be log2(fifo_els_p)+1 bits; the extra wrap bit distinguishes full from empty.
REQ-017 A buffered entry with msg_type e_fe_exception SHALL move e_run to e_fault_wait in the cycle it is written.
- e_fault_wait SHALL drop further FE messages until a redirect is accepted.
REQ-018 Command slot: one register; cmd_ready_o = ~slot_valid.
- redirect_v_i & cmd_ready_o SHALL load redirect_pkt_i, flush all buffer entries next cycle, and enter e_cmd_wait.
- The flush SHALL take priority over a same-cycle push and a same-cycle pop.
REQ-019 attaboy_v_i & cmd_ready_o & ~redirect_v_i SHALL load attaboy_pkt_i without flush or state change.
- When both are requested, redirect SHALL win and the attaboy SHALL be dropped.
- Attaboy is a hint only.
REQ-020 fe_cmd_v_o = slot_valid; fe_cmd_o = slot contents, registered. Latency from request to fe_cmd_v_o SHALL be 1 cycle.
REQ-021 fe_cmd_yumi_i SHALL clear the slot.
- If the slot held a redirect, the state SHALL return to e_run in the same edge.
- fe_cmd_yumi_i with ~fe_cmd_v_o SHALL be ignored.
REQ-022 A new request SHALL NOT load in the cycle the slot is yumied; cmd_ready_o is registered-based.

Reset
REQ-023 On reset_n_i low, asynchronously: state = e_run, pointers = 0, slot_valid = 0.
- Outputs: issue_v_o = 0, fe_cmd_v_o = 0, cmd_ready_o = 1, fe_queue_ready_o = 1.
REQ-024 Buffer data SHALL NOT be reset.
- Reset asserted mid-command SHALL discard the slot; no fe_cmd_v_o SHALL be seen after release until a new request.

Configuration
REQ-025 With BP_BE_FE_QUEUE_RX_STATS_EN defined:
- SHALL add 16-bit saturating output counters drop_count_o and flush_count_o.
- Both SHALL reset to 0.
- drop_count_o SHALL increment per dropped FE message.
- flush_count_o SHALL increment per accepted redirect.
REQ-026 Without BP_BE_FE_QUEUE_RX_STATS_EN: no such ports and no such logic.

Structure
REQ-027 The state enum bp_be_fe_queue_rx_state_e SHALL live in bp_be_pkg; message and command structs SHALL come from the existing FE/BE interface declaration macros.
REQ-028 Storage SHALL be one sub-module, bp_be_fe_queue_rx_fifo, holding pointers, storage and flush; state machine and command slot SHALL remain in the top.

Verification
REQ-029 Push 4 fetch messages (pc 0x8000_0000..0x8000_000C) with no yumi -> fe_queue_ready_o = 0 after the 4th; a 5th is dropped; pops return the 4 in order.
REQ-030 3 entries buffered, then redirect_v_i with vaddr 0x8000_1000 -> next cycle issue_v_o = 0 and fe_cmd_v_o = 1 with vaddr 0x8000_1000; FE messages are dropped until fe_cmd_yumi_i, then accepted.
REQ-031 redirect_v_i and attaboy_v_i in the same cycle -> fe_cmd_o equals the redirect packet; no attaboy is ever emitted.
REQ-032 Push exception e_itlb_miss at vaddr 0x4000 -> entry issues; following fetch messages are dropped until a redirect is accepted and yumied.
REQ-033 Push, pop and redirect all in one cycle at 2 entries -> buffer empty next cycle; pointers wrap correctly over 20 subsequent push/pop pairs.
REQ-034 reset_n_i pulsed low with the slot valid and 2 entries buffered -> outputs reach reset values immediately, without waiting for a clock edge; STATS_EN counters read 0.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared BE-side types for the FE queue receiver: configuration selector,
// FE->BE queue message, BE->FE command, and the receiver state enum.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int vaddr_width_gp = 39;
  localparam int instr_width_gp = 32;

  typedef enum logic [0:0] {
    e_fe_fetch     = 1'b0,
    e_fe_exception = 1'b1
  } bp_fe_msg_type_e;

  typedef enum logic [1:0] {
    e_itlb_miss          = 2'd0,
    e_instr_page_fault   = 2'd1,
    e_instr_access_fault = 2'd2,
    e_illegal_instr      = 2'd3
  } bp_fe_exception_code_e;

  // msg_type sits at the MSB so the receiver can classify a raw message by slicing
  typedef struct packed {
    bp_fe_msg_type_e             msg_type;
    logic [vaddr_width_gp-1:0]   pc;
    bp_fe_exception_code_e       exc_code;
    logic [instr_width_gp-1:0]   instr;
  } bp_fe_queue_s;

  typedef enum logic [2:0] {
    e_op_state_reset    = 3'd0,
    e_op_pc_redirection = 3'd1,
    e_op_attaboy        = 3'd2,
    e_op_icache_fence   = 3'd3,
    e_op_itlb_fill      = 3'd4
  } bp_fe_cmd_opcode_e;

  typedef struct packed {
    bp_fe_cmd_opcode_e           opcode;
    logic [vaddr_width_gp-1:0]   vaddr;
  } bp_fe_cmd_s;

  typedef enum logic [1:0] {
    e_run        = 2'd0,
    e_cmd_wait   = 2'd1,
    e_fault_wait = 2'd2
  } bp_be_fe_queue_rx_state_e;

  function automatic int fe_queue_width_f(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return $bits(bp_fe_queue_s);
      default:          return $bits(bp_fe_queue_s);
    endcase
  endfunction

  function automatic int fe_cmd_width_f(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return $bits(bp_fe_cmd_s);
      default:          return $bits(bp_fe_cmd_s);
    endcase
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_rx_fifo.sv
// FE queue storage: power-of-two ring buffer with wrap-bit pointers and a
// single-cycle flush. Storage contents are intentionally not reset.
module bp_be_fe_queue_rx_fifo #(
  parameter  int width_p      = 1,
  parameter  int els_p        = 4,
  localparam int idx_width_lp = $clog2(els_p),
  localparam int ptr_width_lp = idx_width_lp + 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  input  logic               yumi_i,
  input  logic               flush_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [ptr_width_lp-1:0] wptr_r, rptr_r;
  logic [width_p-1:0]      mem_r [els_p];
  logic                    push, pop;

  assign empty_o = (wptr_r == rptr_r);
  assign full_o  = (wptr_r[idx_width_lp] != rptr_r[idx_width_lp])
                 & (wptr_r[idx_width_lp-1:0] == rptr_r[idx_width_lp-1:0]);
  assign push    = v_i & ~full_o;
  assign pop     = yumi_i & ~empty_o;
  assign data_o  = mem_r[rptr_r[idx_width_lp-1:0]];

  // Pointer update; flush overrides any same-cycle push or pop
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else if (flush_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + 1'b1;
      if (pop)  rptr_r <= rptr_r + 1'b1;
    end
  end

  // Entry write at the tail
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r[idx_width_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_be_fe_queue_rx.sv
// BE receive side of the FE queue: buffers FE messages for issue, holds one
// outgoing FE command (redirect or attaboy), and gates FE traffic while a
// redirect is outstanding or after an exception has been buffered.
// Optional feature macro: BP_BE_FE_QUEUE_RX_STATS_EN adds saturating
// drop_count_o / flush_count_o counters.
//
// state        | meaning
// e_run        | accepting FE messages into the buffer
// e_cmd_wait   | redirect in the slot; FE messages are stale and dropped
// e_fault_wait | exception buffered; FE messages dropped until a redirect
module bp_be_fe_queue_rx
  import bp_be_pkg::*;
#(
  parameter  bp_params_e bp_params_p   = e_bp_default_cfg,
  parameter  int fifo_els_p            = 4,
  localparam int fe_queue_width_lp     = fe_queue_width_f(bp_params_p),
  localparam int fe_cmd_width_lp       = fe_cmd_width_f(bp_params_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0] issue_pkt_o,
  output logic                         issue_v_o,
  input  logic                         issue_yumi_i,
  input  logic                         redirect_v_i,
  input  logic [fe_cmd_width_lp-1:0]   redirect_pkt_i,
  output logic                         cmd_ready_o,
  input  logic                         attaboy_v_i,
  input  logic [fe_cmd_width_lp-1:0]   attaboy_pkt_i,
  output logic [fe_cmd_width_lp-1:0]   fe_cmd_o,
  output logic                         fe_cmd_v_o,
  input  logic                         fe_cmd_yumi_i
`ifdef BP_BE_FE_QUEUE_RX_STATS_EN
 ,output logic [15:0]                  drop_count_o
 ,output logic [15:0]                  flush_count_o
`endif
);

  bp_be_fe_queue_rx_state_e   state_r;
  logic                       slot_valid_r;
  logic                       slot_is_redirect_r;
  logic [fe_cmd_width_lp-1:0] slot_r;
  logic                       full, empty;
  logic                       redirect_accept, attaboy_accept, cmd_yumi;
  logic                       fe_push, fe_is_exc;

  assign cmd_ready_o      = ~slot_valid_r;
  assign fe_queue_ready_o = (state_r != e_cmd_wait) & ~full;
  assign redirect_accept  = redirect_v_i & cmd_ready_o;
  assign attaboy_accept   = attaboy_v_i & cmd_ready_o & ~redirect_v_i;
  assign cmd_yumi         = fe_cmd_yumi_i & slot_valid_r;
  // A redirect in the same cycle flushes, so the incoming message is lost too
  assign fe_push          = fe_queue_v_i & fe_queue_ready_o & (state_r == e_run) & ~redirect_accept;
  assign fe_is_exc        = (bp_fe_msg_type_e'(fe_queue_i[fe_queue_width_lp-1 -: 1]) == e_fe_exception);

  assign issue_v_o  = ~empty;
  assign fe_cmd_v_o = slot_valid_r;
  assign fe_cmd_o   = slot_r;

  bp_be_fe_queue_rx_fifo #(
    .width_p (fe_queue_width_lp),
    .els_p   (fifo_els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (fe_queue_i),
    .v_i       (fe_push),
    .yumi_i    (issue_yumi_i),
    .flush_i   (redirect_accept),
    .data_o    (issue_pkt_o),
    .full_o    (full),
    .empty_o   (empty)
  );

  // State machine and command slot; slot_is_redirect_r decides whether a yumi releases e_cmd_wait
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r            <= e_run;
      slot_valid_r       <= 1'b0;
      slot_is_redirect_r <= 1'b0;
      slot_r             <= '0;
    end else begin
      if (redirect_accept) begin
        slot_valid_r       <= 1'b1;
        slot_is_redirect_r <= 1'b1;
        slot_r             <= redirect_pkt_i;
        state_r            <= e_cmd_wait;
      end else if (attaboy_accept) begin
        slot_valid_r       <= 1'b1;
        slot_is_redirect_r <= 1'b0;
        slot_r             <= attaboy_pkt_i;
      end else if (cmd_yumi) begin
        slot_valid_r <= 1'b0;
        if (slot_is_redirect_r) state_r <= e_run;
      end
      if (fe_push & fe_is_exc) state_r <= e_fault_wait;
    end
  end

`ifdef BP_BE_FE_QUEUE_RX_STATS_EN
  logic fe_drop;
  assign fe_drop = fe_queue_v_i & ~fe_push;

  // Saturating drop and flush statistics
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop_count_o  <= '0;
      flush_count_o <= '0;
    end else begin
      if (fe_drop && drop_count_o != 16'hffff)          drop_count_o  <= drop_count_o + 16'd1;
      if (redirect_accept && flush_count_o != 16'hffff) flush_count_o <= flush_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_rx.sv
// Scoreboard bench for bp_be_fe_queue_rx: stimulus pushes expected issue
// packets and FE commands into queues; monitors pop and compare on handshake.
module tb_bp_be_fe_queue_rx;
  import bp_be_pkg::*;

  localparam int QW = $bits(bp_fe_queue_s);
  localparam int CW = $bits(bp_fe_cmd_s);

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [QW-1:0] fe_queue_i = '0;
  logic          fe_queue_v_i = 1'b0;
  logic          fe_queue_ready_o;
  logic [QW-1:0] issue_pkt_o;
  logic          issue_v_o;
  logic          issue_yumi_i = 1'b0;
  logic          redirect_v_i = 1'b0;
  logic [CW-1:0] redirect_pkt_i = '0;
  logic          cmd_ready_o;
  logic          attaboy_v_i = 1'b0;
  logic [CW-1:0] attaboy_pkt_i = '0;
  logic [CW-1:0] fe_cmd_o;
  logic          fe_cmd_v_o;
  logic          fe_cmd_yumi_i = 1'b0;
`ifdef BP_BE_FE_QUEUE_RX_STATS_EN
  logic [15:0]   drop_count_o;
  logic [15:0]   flush_count_o;
`endif

  bp_be_fe_queue_rx #(.bp_params_p(e_bp_default_cfg), .fifo_els_p(4)) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .issue_pkt_o      (issue_pkt_o),
    .issue_v_o        (issue_v_o),
    .issue_yumi_i     (issue_yumi_i),
    .redirect_v_i     (redirect_v_i),
    .redirect_pkt_i   (redirect_pkt_i),
    .cmd_ready_o      (cmd_ready_o),
    .attaboy_v_i      (attaboy_v_i),
    .attaboy_pkt_i    (attaboy_pkt_i),
    .fe_cmd_o         (fe_cmd_o),
    .fe_cmd_v_o       (fe_cmd_v_o),
    .fe_cmd_yumi_i    (fe_cmd_yumi_i)
`ifdef BP_BE_FE_QUEUE_RX_STATS_EN
   ,.drop_count_o     (drop_count_o)
   ,.flush_count_o    (flush_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  logic [QW-1:0] exp_q [$];
  logic [CW-1:0] cmd_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [QW-1:0] fetch(input logic [38:0] pc);
    bp_fe_queue_s p;
    p.msg_type = e_fe_fetch;
    p.pc       = pc;
    p.exc_code = e_itlb_miss;
    p.instr    = pc[31:0] ^ 32'h0000_0013;
    return p;
  endfunction

  function automatic logic [QW-1:0] exc(input logic [38:0] pc, input bp_fe_exception_code_e code);
    bp_fe_queue_s p;
    p.msg_type = e_fe_exception;
    p.pc       = pc;
    p.exc_code = code;
    p.instr    = 32'h0;
    return p;
  endfunction

  function automatic logic [CW-1:0] mk_cmd(input bp_fe_cmd_opcode_e op, input logic [38:0] va);
    bp_fe_cmd_s c;
    c.opcode = op;
    c.vaddr  = va;
    return c;
  endfunction

  // Issue-side monitor
  always @(negedge clk_i) begin
    if (reset_n_i && issue_v_o && issue_yumi_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL issue_unexpected: got %0h expected none", issue_pkt_o);
      end else begin
        check("issue_pkt", issue_pkt_o, exp_q.pop_front());
      end
    end
  end

  // Command-side monitor
  always @(negedge clk_i) begin
    if (reset_n_i && fe_cmd_v_o && fe_cmd_yumi_i) begin
      if (cmd_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL cmd_unexpected: got %0h expected none", fe_cmd_o);
      end else begin
        check("fe_cmd", fe_cmd_o, cmd_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [QW-1:0] pkt, input bit exp_acc);
    fe_queue_i   = pkt;
    fe_queue_v_i = 1'b1;
    if (exp_acc) exp_q.push_back(pkt);
    step();
    fe_queue_v_i = 1'b0;
  endtask

  task automatic pop();
    issue_yumi_i = 1'b1;
    step();
    issue_yumi_i = 1'b0;
  endtask

  task automatic redirect(input logic [38:0] va);
    redirect_pkt_i = mk_cmd(e_op_pc_redirection, va);
    redirect_v_i   = 1'b1;
    cmd_q.push_back(redirect_pkt_i);
    step();
    redirect_v_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic cmd_yumi();
    fe_cmd_yumi_i = 1'b1;
    step();
    fe_cmd_yumi_i = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_issue_v", issue_v_o, 0);
    check("rst_cmd_v", fe_cmd_v_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_fe_ready", fe_queue_ready_o, 1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step();

    // Fill to full, drop a fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", fe_queue_ready_o, 1);
      push(fetch(39'h80000000 + 39'(4 * i)), 1'b1);
    end
    check("full_ready", fe_queue_ready_o, 0);
    check("full_issue_v", issue_v_o, 1);
    push(fetch(39'h80000010), 1'b0);
    for (int i = 0; i < 4; i++) pop();
    check("drained_issue_v", issue_v_o, 0);

    // Redirect flushes three entries, gates FE until yumi
    for (int i = 0; i < 3; i++) push(fetch(39'h90000000 + 39'(4 * i)), 1'b1);
    redirect(39'h80001000);
    check("redir_issue_v", issue_v_o, 0);
    check("redir_cmd_v", fe_cmd_v_o, 1);
    check("redir_cmd_val", fe_cmd_o, mk_cmd(e_op_pc_redirection, 39'h80001000));
    check("redir_cmd_ready", cmd_ready_o, 0);
    check("redir_fe_ready", fe_queue_ready_o, 0);
    push(fetch(39'h90000100), 1'b0);
    check("cmdwait_drop", issue_v_o, 0);
    cmd_yumi();
    check("yumi_cmd_v", fe_cmd_v_o, 0);
    check("yumi_fe_ready", fe_queue_ready_o, 1);
    push(fetch(39'h80001000), 1'b1);
    check("post_redir_issue_v", issue_v_o, 1);
    pop();

    // Attaboy alone: no flush, no gating
    attaboy_pkt_i = mk_cmd(e_op_attaboy, 39'h00005000);
    attaboy_v_i   = 1'b1;
    cmd_q.push_back(attaboy_pkt_i);
    step();
    attaboy_v_i = 1'b0;
    check("atta_cmd_v", fe_cmd_v_o, 1);
    check("atta_fe_ready", fe_queue_ready_o, 1);
    push(fetch(39'h00005000), 1'b1);
    check("atta_push_issue_v", issue_v_o, 1);
    cmd_yumi();
    pop();

    // Redirect and attaboy together: redirect wins
    attaboy_pkt_i = mk_cmd(e_op_attaboy, 39'h00006000);
    attaboy_v_i   = 1'b1;
    redirect(39'h00007000);
    attaboy_v_i = 1'b0;
    check("both_cmd_val", fe_cmd_o, mk_cmd(e_op_pc_redirection, 39'h00007000));
    cmd_yumi();
    step();
    check("no_attaboy_1", fe_cmd_v_o, 0);
    step();
    check("no_attaboy_2", fe_cmd_v_o, 0);

    // Exception gating
    push(exc(39'h4000, e_itlb_miss), 1'b1);
    check("exc_issue_v", issue_v_o, 1);
    pop();
    push(fetch(39'h4004), 1'b0);
    check("fault_drop_1", issue_v_o, 0);
    check("fault_ready", fe_queue_ready_o, 1);
    push(fetch(39'h4008), 1'b0);
    check("fault_drop_2", issue_v_o, 0);
    redirect(39'h80002000);
    push(fetch(39'h400c), 1'b0);
    check("fault_cmdwait_drop", issue_v_o, 0);
    cmd_yumi();
    push(fetch(39'h80002000), 1'b1);
    check("fault_cleared", issue_v_o, 1);
    pop();

    // Push, pop and redirect in one cycle at two entries
    push(fetch(39'h000b0), 1'b1);
    push(fetch(39'h000b4), 1'b1);
    fe_queue_i   = fetch(39'h000b8);
    fe_queue_v_i = 1'b1;
    issue_yumi_i = 1'b1;
    redirect(39'h0000c000);
    fe_queue_v_i = 1'b0;
    issue_yumi_i = 1'b0;
    check("ppr_issue_v", issue_v_o, 0);
    cmd_yumi();
    for (int i = 0; i < 20; i++) begin
      push(fetch(39'h0000c000 + 39'(4 * i)), 1'b1);
      check("wrap_issue_v", issue_v_o, 1);
      pop();
      check("wrap_empty", issue_v_o, 0);
    end

    // Asynchronous reset with slot valid and two entries buffered
    push(fetch(39'h000d0), 1'b1);
    push(fetch(39'h000d4), 1'b1);
    attaboy_pkt_i = mk_cmd(e_op_attaboy, 39'h000d8);
    attaboy_v_i   = 1'b1;
    step();
    attaboy_v_i = 1'b0;
    check("pre_rst_cmd_v", fe_cmd_v_o, 1);
    check("pre_rst_issue_v", issue_v_o, 1);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("arst_issue_v", issue_v_o, 0);
    check("arst_cmd_v", fe_cmd_v_o, 0);
    check("arst_cmd_ready", cmd_ready_o, 1);
    check("arst_fe_ready", fe_queue_ready_o, 1);
`ifdef BP_BE_FE_QUEUE_RX_STATS_EN
    check("arst_drop_count", drop_count_o, 0);
    check("arst_flush_count", flush_count_o, 0);
`endif
    exp_q.delete();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_cmd_v", fe_cmd_v_o, 0);
      check("post_rst_issue_v", issue_v_o, 0);
    end

    check("issue_leftover", exp_q.size(), 0);
    check("cmd_leftover", cmd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
